// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that multiplexes NUM_CH requesters onto one tagged memory port
// and routes tagged load responses back to the channel that issued them.
module mem_port_arbiter #(
   parameter int NUM_CH  = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int TAG_W   = 4,
   parameter int MAX_OUT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req_valid,
   input  logic [2*NUM_CH-1:0]      req_cmd,
   input  logic [ADDR_W*NUM_CH-1:0] req_addr,
   input  logic [DATA_W*NUM_CH-1:0] req_data,
   output logic [NUM_CH-1:0]        req_ready,
   output logic [NUM_CH-1:0]        rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic [1:0]               proc2mem_command,
   output logic [ADDR_W-1:0]        proc2mem_addr,
   output logic [DATA_W-1:0]        proc2mem_data,
   input  logic [TAG_W-1:0]         mem2proc_transaction_tag,
   input  logic [DATA_W-1:0]        mem2proc_data,
   input  logic [TAG_W-1:0]         mem2proc_data_tag,
   output logic                     idle,
   output logic                     err
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam int TBL   = 1 << TAG_W;

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;

   logic [CH_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  out_cnt [NUM_CH];
   logic              tbl_valid [TBL];
   logic [CH_W-1:0]   tbl_owner [TBL];

   logic [NUM_CH-1:0] elig;
   logic              found;
   logic              grant;
   logic [CH_W-1:0]   winner;
   logic [CH_W-1:0]   next_ptr;
   logic [1:0]        win_cmd;
   logic              accept;
   logic              accept_load;
   logic              rsp_hit;
   logic              unknown_tag;
   logic              reuse_err;
   logic [NUM_CH-1:0] rsp_onehot;
   logic [NUM_CH-1:0] cnt_inc;
   logic              cnt_zero;

   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         case (req_cmd[2*i +: 2])
            CMD_LOAD:  elig[i] = req_valid[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
            CMD_STORE: elig[i] = req_valid[i];
            default:   elig[i] = 1'b0;
         endcase
      end
   end

   // First eligible channel at or after rr_ptr, wrapping.
   always_comb begin
      logic [CH_W-1:0] idx;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         idx = CH_W'((32'(rr_ptr) + k) % NUM_CH);
         if (!found && elig[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      grant            = found && !rst;
      win_cmd          = req_cmd[2*winner +: 2];
      proc2mem_command = grant ? win_cmd : CMD_NONE;
      proc2mem_addr    = grant ? req_addr[ADDR_W*winner +: ADDR_W] : '0;
      proc2mem_data    = grant ? req_data[DATA_W*winner +: DATA_W] : '0;
      accept           = grant && (mem2proc_transaction_tag != '0);
      accept_load      = accept && (win_cmd == CMD_LOAD);
      req_ready        = accept ? (NUM_CH'(1) << winner) : '0;
      next_ptr         = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
   end

   always_comb begin
      rsp_hit     = (mem2proc_data_tag != '0) && tbl_valid[mem2proc_data_tag];
      unknown_tag = (mem2proc_data_tag != '0) && !tbl_valid[mem2proc_data_tag];
      // A same-cycle response on the accepted tag frees it first, so that case is legal reuse.
      reuse_err   = accept_load && tbl_valid[mem2proc_transaction_tag] &&
                    !(rsp_hit && (mem2proc_data_tag == mem2proc_transaction_tag));
      rsp_onehot  = '0;
      cnt_inc     = '0;
      cnt_zero    = 1'b1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         rsp_onehot[i] = rsp_hit && (tbl_owner[mem2proc_data_tag] == CH_W'(i));
         cnt_inc[i]    = accept_load && (winner == CH_W'(i));
         if (out_cnt[i] != '0) cnt_zero = 1'b0;
      end
      idle = (elig == '0) && cnt_zero && (rsp_valid == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         err       <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) out_cnt[i] <= '0;
         for (int unsigned t = 0; t < TBL; t++) begin
            tbl_valid[t] <= 1'b0;
            tbl_owner[t] <= '0;
         end
      end else begin
         if (accept) rr_ptr <= next_ptr;
         // Free before allocate: a same-tag accept must win over the response clear.
         if (rsp_hit) tbl_valid[mem2proc_data_tag] <= 1'b0;
         if (accept_load) begin
            tbl_valid[mem2proc_transaction_tag] <= 1'b1;
            tbl_owner[mem2proc_transaction_tag] <= winner;
         end
         rsp_valid <= rsp_onehot;
         if (rsp_hit) rsp_data <= mem2proc_data;
         if (unknown_tag || reuse_err) err <= 1'b1;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cnt_inc[i] && !rsp_onehot[i])      out_cnt[i] <= out_cnt[i] + CNT_W'(1);
            else if (rsp_onehot[i] && !cnt_inc[i]) out_cnt[i] <= out_cnt[i] - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations for grant order,
// tag routing, backpressure, same-cycle reuse, sticky error and async reset.
module tb_mem_port_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [7:0]   req_cmd;
   logic [127:0] req_addr;
   logic [255:0] req_data;
   logic [3:0]   req_ready;
   logic [3:0]   rsp_valid;
   logic [63:0]  rsp_data;
   logic [1:0]   proc2mem_command;
   logic [31:0]  proc2mem_addr;
   logic [63:0]  proc2mem_data;
   logic [3:0]   mem2proc_transaction_tag;
   logic [63:0]  mem2proc_data;
   logic [3:0]   mem2proc_data_tag;
   logic         idle;
   logic         err;

   int n_vec = 0;
   int n_err = 0;

   mem_port_arbiter #(
      .NUM_CH(4), .ADDR_W(32), .DATA_W(64), .TAG_W(4), .MAX_OUT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data),
      .mem2proc_transaction_tag(mem2proc_transaction_tag),
      .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag),
      .idle(idle), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int ch, input logic [1:0] cmd, input logic [31:0] a, input logic [63:0] d);
      req_valid[ch]       = 1'b1;
      req_cmd[2*ch +: 2]  = cmd;
      req_addr[32*ch +: 32] = a;
      req_data[64*ch +: 64] = d;
   endtask

   task automatic clear_in();
      req_valid = '0;
      req_cmd   = '0;
      req_addr  = '0;
      req_data  = '0;
      mem2proc_transaction_tag = '0;
      mem2proc_data_tag        = '0;
      mem2proc_data            = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_in();
      cyc();
      cyc();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      clear_in();
      rst = 1'b1;
      set_req(0, 2'd1, 32'h100, 64'h0);
      #3;
      // Reset state, with a request present to show grant is suppressed.
      check_eq("rst_ready", 64'(req_ready), 64'h0);
      check_eq("rst_cmd", 64'(proc2mem_command), 64'h0);
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check_eq("rst_rsp_data", rsp_data, 64'h0);
      check_eq("rst_err", 64'(err), 64'h0);
      cyc();
      clear_in();
      rst = 1'b0;
      #1;
      check_eq("rst_idle", 64'(idle), 64'h1);

      // Single load on ch0, tag 3, data returned two cycles later.
      cyc();
      set_req(0, 2'd1, 32'h100, 64'h0);
      mem2proc_transaction_tag = 4'd3;
      #1;
      check_eq("t1_cmd", 64'(proc2mem_command), 64'h1);
      check_eq("t1_addr", 64'(proc2mem_addr), 64'h100);
      check_eq("t1_ready", 64'(req_ready), 64'h1);
      cyc();
      clear_in();
      #1;
      check_eq("t1_idle_busy", 64'(idle), 64'h0);
      cyc();
      mem2proc_data_tag = 4'd3;
      mem2proc_data     = 64'hDEADBEEF_00000001;
      #1;
      check_eq("t1_rsp_early", 64'(rsp_valid), 64'h0);
      cyc();
      clear_in();
      #1;
      check_eq("t1_rsp_valid", 64'(rsp_valid), 64'h1);
      check_eq("t1_rsp_data", rsp_data, 64'hDEADBEEF_00000001);
      check_eq("t1_idle_pend", 64'(idle), 64'h0);
      cyc();
      check_eq("t1_rsp_clr", 64'(rsp_valid), 64'h0);
      check_eq("t1_rsp_hold", rsp_data, 64'hDEADBEEF_00000001);
      check_eq("t1_idle", 64'(idle), 64'h1);
      check_eq("t1_err", 64'(err), 64'h0);

      // All four channels loading, memory accepting with fresh tags.
      do_reset();
      cyc();
      for (int c = 0; c < 4; c++) set_req(c, 2'd1, 32'h1000 + 32'(c), 64'h0);
      for (int k = 0; k < 13; k++) begin
         mem2proc_transaction_tag = 4'(k + 1);
         #1;
         check_eq($sformatf("t2_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
         check_eq($sformatf("t2_addr_%0d", k), 64'(proc2mem_addr), 64'(32'h1000 + 32'(k % 4)));
         cyc();
      end
      // ch0 is now at MAX_OUT and must be skipped.
      mem2proc_transaction_tag = 4'd14;
      #1;
      check_eq("t2_ready_13", 64'(req_ready), 64'h2);
      cyc();
      mem2proc_transaction_tag = 4'd15;
      #1;
      check_eq("t2_ready_14", 64'(req_ready), 64'h4);
      cyc();
      mem2proc_transaction_tag = 4'd0;
      #1;
      check_eq("t2_full_addr", 64'(proc2mem_addr), 64'h1003);
      check_eq("t2_full_ready", 64'(req_ready), 64'h0);
      cyc();
      check_eq("t2_full_addr2", 64'(proc2mem_addr), 64'h1003);
      check_eq("t2_err", 64'(err), 64'h0);

      // Async reset with loads in flight, then a stale tag returns.
      #2;
      rst = 1'b1;
      #1;
      check_eq("t6_ready", 64'(req_ready), 64'h0);
      check_eq("t6_cmd", 64'(proc2mem_command), 64'h0);
      check_eq("t6_rsp", 64'(rsp_valid), 64'h0);
      clear_in();
      #3;
      rst = 1'b0;
      cyc();
      check_eq("t6_idle", 64'(idle), 64'h1);
      mem2proc_data_tag = 4'd5;
      mem2proc_data     = 64'h1234;
      cyc();
      clear_in();
      #1;
      check_eq("t6_err", 64'(err), 64'h1);
      check_eq("t6_no_rsp", 64'(rsp_valid), 64'h0);
      cyc();
      check_eq("t6_err_sticky", 64'(err), 64'h1);

      // ch2 store, rejected three cycles, then accepted with tag 5.
      do_reset();
      cyc();
      set_req(2, 2'd2, 32'h2000, 64'h55);
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq($sformatf("t3_cmd_%0d", k), 64'(proc2mem_command), 64'h2);
         check_eq($sformatf("t3_ready_%0d", k), 64'(req_ready), 64'h0);
         cyc();
      end
      mem2proc_transaction_tag = 4'd5;
      #1;
      check_eq("t3_cmd_acc", 64'(proc2mem_command), 64'h2);
      check_eq("t3_addr", 64'(proc2mem_addr), 64'h2000);
      check_eq("t3_data", proc2mem_data, 64'h55);
      check_eq("t3_ready", 64'(req_ready), 64'h4);
      cyc();
      clear_in();
      set_req(0, 2'd2, 32'hA0, 64'h0);
      set_req(1, 2'd2, 32'hA1, 64'h0);
      set_req(3, 2'd2, 32'hA3, 64'h0);
      #1;
      check_eq("t3_rr_ptr3", 64'(proc2mem_addr), 64'hA3);
      clear_in();
      #1;
      check_eq("t3_idle", 64'(idle), 64'h1);
      cyc();
      mem2proc_data_tag = 4'd5;
      cyc();
      clear_in();
      #1;
      check_eq("t3_err", 64'(err), 64'h1);
      check_eq("t3_no_rsp", 64'(rsp_valid), 64'h0);

      // Out-of-order return: ch1 tag 1, ch3 tag 2.
      do_reset();
      cyc();
      set_req(1, 2'd1, 32'h310, 64'h0);
      mem2proc_transaction_tag = 4'd1;
      #1;
      check_eq("t4_ready1", 64'(req_ready), 64'h2);
      cyc();
      clear_in();
      set_req(3, 2'd1, 32'h330, 64'h0);
      mem2proc_transaction_tag = 4'd2;
      #1;
      check_eq("t4_ready3", 64'(req_ready), 64'h8);
      cyc();
      clear_in();
      mem2proc_data_tag = 4'd2;
      mem2proc_data     = 64'hAAAA_0003;
      cyc();
      check_eq("t4_rsp_ch3", 64'(rsp_valid), 64'h8);
      check_eq("t4_data_ch3", rsp_data, 64'hAAAA_0003);
      mem2proc_data_tag = 4'd1;
      mem2proc_data     = 64'hBBBB_0001;
      cyc();
      clear_in();
      #1;
      check_eq("t4_rsp_ch1", 64'(rsp_valid), 64'h2);
      check_eq("t4_data_ch1", rsp_data, 64'hBBBB_0001);
      cyc();
      check_eq("t4_idle", 64'(idle), 64'h1);
      check_eq("t4_err", 64'(err), 64'h0);

      // Same-cycle response and new accept on tag 4, both ch0.
      set_req(0, 2'd1, 32'h400, 64'h0);
      mem2proc_transaction_tag = 4'd4;
      #1;
      check_eq("t5_ready_a", 64'(req_ready), 64'h1);
      cyc();
      set_req(0, 2'd1, 32'h404, 64'h0);
      mem2proc_transaction_tag = 4'd4;
      mem2proc_data_tag        = 4'd4;
      mem2proc_data            = 64'hC0C0_0004;
      #1;
      check_eq("t5_ready_b", 64'(req_ready), 64'h1);
      cyc();
      clear_in();
      #1;
      check_eq("t5_rsp", 64'(rsp_valid), 64'h1);
      check_eq("t5_rsp_data", rsp_data, 64'hC0C0_0004);
      check_eq("t5_err", 64'(err), 64'h0);
      cyc();
      check_eq("t5_cnt_kept", 64'(idle), 64'h0);
      mem2proc_data_tag = 4'd4;
      mem2proc_data     = 64'hD0D0_0004;
      cyc();
      clear_in();
      #1;
      check_eq("t5_rsp2", 64'(rsp_valid), 64'h1);
      check_eq("t5_rsp2_data", rsp_data, 64'hD0D0_0004);
      check_eq("t5_err2", 64'(err), 64'h0);
      cyc();
      check_eq("t5_idle", 64'(idle), 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
